// File: rtl/display_scan_bcd.sv
// rtl/display_scan_bcd.sv - binary to 3-digit BCD (sequential double-dabble) with scanned digit output
//
// Purpose:
//   Converts the binary distance value valor into hundreds/tens/units BCD digits
//   with one double-dabble step per clock, then time-multiplexes the committed
//   digits toward a 7-segment decoder.
//
// Ports:
//   clk      in   1     system clock, rising edge
//   reset    in   1     synchronous, active-high reset
//   valor    in   IN_W  binary value to display
//   load     in   1     start strobe, honoured only while idle
//   busy     out  1     conversion in progress (CONV and UPD states)
//   done     out  1     one-cycle pulse once new digits are committed
//   over     out  1     last loaded valor exceeded 999
//   mostrar  out  2     digit select: 01 hundreds, 10 tens, 11 units
//   digito   out  4     BCD digit for the selected position
//
// Configuration macro:
//   DISPLAY_OVER_SAT_EN  when defined, an over-range value commits 9,9,9;
//                        otherwise the low three decimal digits are shown.

module display_scan_bcd #(
    parameter int IN_W = 10,
    parameter int DIV  = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] valor,
    input  logic            load,
    output logic            busy,
    output logic            done,
    output logic            over,
    output logic [1:0]      mostrar,
    output logic [3:0]      digito
);

    localparam int CNT_W  = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int SCAN_W = $clog2(DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        UPD  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IN_W-1:0]   bin;
    logic [15:0]       bcd;       // thousands, hundreds, tens, units nibbles
    logic [15:0]       bcd_adj;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_bit;
    logic              valor_big;
    logic              commit;
    logic [3:0]        dig_h;
    logic [3:0]        dig_t;
    logic [3:0]        dig_u;
    logic [SCAN_W-1:0] scan_cnt;

    assign last_bit  = (bit_cnt == CNT_W'(IN_W - 1));
    assign valor_big = (32'(valor) > 32'd999);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (last_bit) state_next = UPD;
            UPD:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy   = 1'b0;
        commit = 1'b0;
        case (state)
            CONV:    busy = 1'b1;
            UPD:     begin busy = 1'b1; commit = 1'b1; end
            default: begin busy = 1'b0; commit = 1'b0; end
        endcase
    end

    // Double-dabble correction: any nibble of 5 or more gets +3 before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath and committed display registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bin     <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            over    <= 1'b0;
            done    <= 1'b0;
            dig_h   <= 4'd0;
            dig_t   <= 4'd0;
            dig_u   <= 4'd0;
        end else begin
            // done is raised on the same edge the digits change, so it marks them valid
            done <= commit;
            case (state)
                IDLE: begin
                    if (load) begin
                        bin     <= valor;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        over    <= valor_big;
                    end
                end
                CONV: begin
                    {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
                    bit_cnt    <= bit_cnt + 1'b1;
                end
                UPD: begin
`ifdef DISPLAY_OVER_SAT_EN
                    if (over) begin
                        dig_h <= 4'd9;
                        dig_t <= 4'd9;
                        dig_u <= 4'd9;
                    end else begin
                        dig_h <= bcd[11:8];
                        dig_t <= bcd[7:4];
                        dig_u <= bcd[3:0];
                    end
`else
                    // thousands nibble bcd[15:12] is intentionally dropped
                    dig_h <= bcd[11:8];
                    dig_t <= bcd[7:4];
                    dig_u <= bcd[3:0];
`endif
                end
                default: ;
            endcase
        end
    end

    // Scan timing: independent of conversion, so a commit never shifts the phase
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            mostrar  <= 2'b01;
        end else if (scan_cnt == SCAN_W'(DIV - 1)) begin
            scan_cnt <= '0;
            mostrar  <= (mostrar == 2'b11) ? 2'b01 : mostrar + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Digit mux; 00 cannot occur but still decodes to a legal digit
    always_comb begin
        digito = 4'd0;
        case (mostrar)
            2'b01:   digito = dig_h;
            2'b10:   digito = dig_t;
            2'b11:   digito = dig_u;
            default: digito = 4'd0;
        endcase
    end

endmodule

// File: tb/tb_display_scan_bcd.sv
// tb/tb_display_scan_bcd.sv - directed self-checking bench for display_scan_bcd

module tb_display_scan_bcd;

    localparam int IN_W = 10;
    localparam int DIV  = 4;

    logic            clk;
    logic            reset;
    logic [IN_W-1:0] valor;
    logic            load;
    logic            busy;
    logic            done;
    logic            over;
    logic [1:0]      mostrar;
    logic [3:0]      digito;

    int total = 0;
    int bad   = 0;

    // reference scan phase: 4 cycles per digit, 01 -> 10 -> 11 -> 01
    int       m_cnt;
    logic [1:0] m_sel;

    display_scan_bcd #(.IN_W(IN_W), .DIV(DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .valor   (valor),
        .load    (load),
        .busy    (busy),
        .done    (done),
        .over    (over),
        .mostrar (mostrar),
        .digito  (digito)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt <= 0;
            m_sel <= 2'b01;
        end else if (m_cnt == DIV - 1) begin
            m_cnt <= 0;
            m_sel <= (m_sel == 2'b11) ? 2'b01 : m_sel + 2'd1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // waits (bounded) for each select code and checks the digit shown there
    task automatic show_check(input string tag, input int h, input int t, input int u);
        int exp_d [3];
        logic [1:0] sel;
        int n;
        exp_d[0] = h; exp_d[1] = t; exp_d[2] = u;
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k + 1);
            n = 0;
            while (mostrar !== sel && n < 16) begin
                @(negedge clk);
                n++;
            end
            check({tag, "_sel_found"}, int'(mostrar === sel), 1);
            check({tag, "_digit"}, int'(digito), exp_d[k]);
        end
    endtask

    // strobes load; optionally re-strobes mid-conversion; checks busy length and done pulse
    task automatic run_load(input string tag, input int v, input int again, input int v2);
        int n;
        valor = IN_W'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            check({tag, "_no_done_while_busy"}, int'(done), 0);
            if (again != 0 && n == 3) begin
                valor = IN_W'(v2);
                load  = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
            n++;
        end
        check({tag, "_busy_cycles"}, n, IN_W + 1);
        check({tag, "_done_pulse"}, int'(done), 1);
        @(negedge clk);
        check({tag, "_done_low_after"}, int'(done), 0);
        check({tag, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        valor = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_over", int'(over), 0);
        check("rst_mostrar", int'(mostrar), 1);
        check("rst_digito", int'(digito), 0);

        // free run: select follows the 4-cycle phase and never reads 00
        for (int i = 0; i < 12; i++) begin
            check("scan_phase", int'(mostrar), int'(m_sel));
            check("scan_not_00", int'(mostrar != 2'b00), 1);
            @(negedge clk);
        end

        run_load("v345", 345, 0, 0);
        check("v345_over", int'(over), 0);
        show_check("v345", 3, 4, 5);
        check("v345_phase", int'(mostrar), int'(m_sel));

        run_load("v999", 999, 1, 0);
        check("v999_over", int'(over), 0);
        show_check("v999", 9, 9, 9);

        run_load("v1023", 1023, 0, 0);
        check("v1023_over", int'(over), 1);
`ifdef DISPLAY_OVER_SAT_EN
        show_check("v1023", 9, 9, 9);
`else
        show_check("v1023", 0, 2, 3);
`endif

        run_load("v7", 7, 0, 0);
        check("v7_over_cleared", int'(over), 0);
        show_check("v7", 0, 0, 7);

        // reset mid-conversion aborts everything
        valor = IN_W'(512);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_over", int'(over), 0);
        check("abort_mostrar", int'(mostrar), 1);
        for (int i = 0; i < 20; i++) begin
            check("abort_no_done", int'(done), 0);
            @(negedge clk);
        end
        show_check("abort", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
